online_r4_result_checker: RTL and testbench

- Downstream consumer of the radix-4 online adder's output stream.
- Receives the adder's N+1 result digits serially, most significant digit (MSD) first, each qualified by a valid strobe.
- Compares the stream against the expected result vector supplied by the test-vector source and reports pass/fail, mismatch count, first failing index, illegal digits and timeout.
- Lets the adder test harness run self-checking on hardware.

---
 rtl/online_r4_result_checker.sv | 130 +++++++++++++
 tb/tb_online_r4_result_checker.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/online_r4_result_checker.sv
// online_r4_result_checker: checks the serial MSD-first radix-4 online adder result against an expected vector.
// Optional ONLINE_R4_VALUE_CHECK_EN judges pass on numeric value instead of digit-exact equality.
module online_r4_result_checker #(
  parameter int N = 6,
  parameter int C = 3,
  parameter int TIMEOUT = 32,
  parameter int IW = $clog2(N + 2)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [(N+1)*C-1:0]   exp_z,
  input  logic                 dig_valid,
  input  logic [C-1:0]         dig_in,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [IW-1:0]        mismatch_count,
  output logic [IW-1:0]        first_err_idx,
  output logic                 illegal_digit,
`ifdef ONLINE_R4_VALUE_CHECK_EN
  output logic                 value_match,
`endif
  output logic                 timeout
);
  localparam int W = (N + 1) * C;
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  state_t state;
  logic [W-1:0] exp_sr;
  logic [IW-1:0] idx;
  logic [TW-1:0] idle_cnt;
  logic [C-1:0] exp_dig;
  logic bad_dig, mis, last, tout, ill_n, pass_n;
  logic [IW-1:0] mc_n;
`ifdef ONLINE_R4_VALUE_CHECK_EN
  localparam int AW = 2 * (N + 1) + 2;
  logic signed [AW-1:0] acc_r, acc_e, acc_r_n, acc_e_n;
`endif
  always_comb begin
    exp_dig = exp_sr[W-1 -: C];
    bad_dig = dig_in == {1'b1, {(C-1){1'b0}}};
    mis = bad_dig || dig_in != exp_dig;
    last = idx == IW'(N);
    tout = idle_cnt == TW'(TIMEOUT - 1);
    mc_n = (dig_valid && mis && mismatch_count != '1) ? mismatch_count + 1'b1 : mismatch_count;
    ill_n = illegal_digit | (dig_valid & bad_dig);
`ifdef ONLINE_R4_VALUE_CHECK_EN
    acc_r_n = (acc_r <<< 2) + {{(AW-C){dig_in[C-1]}}, dig_in};
    acc_e_n = (acc_e <<< 2) + {{(AW-C){exp_dig[C-1]}}, exp_dig};
    pass_n = acc_r_n == acc_e_n && !ill_n;
`else
    pass_n = mc_n == '0 && !ill_n;
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      exp_sr <= '0;
      idx <= '0;
      idle_cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      mismatch_count <= '0;
      first_err_idx <= IW'(N + 1);
      illegal_digit <= 1'b0;
      timeout <= 1'b0;
`ifdef ONLINE_R4_VALUE_CHECK_EN
      acc_r <= '0;
      acc_e <= '0;
      value_match <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          exp_sr <= exp_z;
          idx <= '0;
          idle_cnt <= '0;
          busy <= 1'b1;
          pass <= 1'b0;
          mismatch_count <= '0;
          first_err_idx <= IW'(N + 1);
          illegal_digit <= 1'b0;
          timeout <= 1'b0;
`ifdef ONLINE_R4_VALUE_CHECK_EN
          acc_r <= '0;
          acc_e <= '0;
          value_match <= 1'b0;
`endif
          state <= RUN;
        end
        RUN: if (dig_valid) begin
          exp_sr <= exp_sr << C;
          idx <= idx + 1'b1;
          idle_cnt <= '0;
          mismatch_count <= mc_n;
          illegal_digit <= ill_n;
          // a zero count means no earlier mismatch, so this index is the first
          if (mis && mismatch_count == '0) first_err_idx <= idx;
`ifdef ONLINE_R4_VALUE_CHECK_EN
          acc_r <= acc_r_n;
          acc_e <= acc_e_n;
          if (last) value_match <= acc_r_n == acc_e_n;
`endif
          if (last) begin
            pass <= pass_n;
            busy <= 1'b0;
            done <= 1'b1;
            state <= FINISH;
          end
        end else if (tout) begin
          timeout <= 1'b1;
          pass <= 1'b0;
          busy <= 1'b0;
          done <= 1'b1;
`ifdef ONLINE_R4_VALUE_CHECK_EN
          value_match <= acc_r == acc_e;
`endif
          state <= FINISH;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_online_r4_result_checker.sv
// tb_online_r4_result_checker: directed and randomized checks against a digit-list reference model.
module tb_online_r4_result_checker;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, dig_valid = 1'b0;
  logic [2:0] dig_in = 3'd0;
  logic [20:0] exp_z = 21'd0;
  logic busy, done, pass, illegal_digit, timeout;
  logic [2:0] mismatch_count, first_err_idx;
`ifdef ONLINE_R4_VALUE_CHECK_EN
  logic value_match;
`endif
  int checks = 0, errors = 0;
  int ev[7], gv[7];

  online_r4_result_checker dut (
    .clk(clk), .rst_n(rst_n), .start(start), .exp_z(exp_z),
    .dig_valid(dig_valid), .dig_in(dig_in), .busy(busy), .done(done),
    .pass(pass), .mismatch_count(mismatch_count), .first_err_idx(first_err_idx),
    .illegal_digit(illegal_digit),
`ifdef ONLINE_R4_VALUE_CHECK_EN
    .value_match(value_match),
`endif
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [20:0] pack_exp();
    logic [20:0] p;
    for (int i = 0; i < 7; i++) p[(6-i)*3 +: 3] = 3'(ev[i]);
    return p;
  endfunction

  // Drive one check; nsend<7 leaves the stream short to provoke a timeout.
  task automatic run_check(input string tag, input int gap, input int nsend, input bit same, input bit poke);
    int mc, fe, vr, ve, cyc;
    bit ill, to, ok;
    mc = 0; fe = 7; ill = 0; vr = 0; ve = 0;
    for (int i = 0; i < nsend; i++) begin
      if (gv[i] != ev[i] || gv[i] == -4) begin
        if (mc == 0) fe = i;
        mc++;
      end
      if (gv[i] == -4) ill = 1;
      vr = vr * 4 + gv[i];
      ve = ve * 4 + ev[i];
    end
    to = nsend < 7;
`ifdef ONLINE_R4_VALUE_CHECK_EN
    ok = vr == ve && !ill && !to;
`else
    ok = mc == 0 && !ill && !to;
`endif
    exp_z = pack_exp();
    start = 1'b1;
    dig_valid = same;
    dig_in = 3'b011;
    tick;
    start = 1'b0;
    dig_valid = 1'b0;
    chk({tag, ".busy"}, busy, 1);
    for (int i = 0; i < nsend; i++) begin
      repeat (gap) tick;
      dig_valid = 1'b1;
      dig_in = 3'(gv[i]);
      if (poke && i == 3) begin
        start = 1'b1;
        exp_z = ~exp_z;
      end
      tick;
      dig_valid = 1'b0;
      start = 1'b0;
      if (i == 5) chk({tag, ".early_done"}, done, 0);
    end
    if (to) begin
      cyc = 0;
      while (!done && cyc < 100) begin
        tick;
        cyc++;
      end
      chk({tag, ".timeout_cycles"}, cyc, 32);
    end
    chk({tag, ".done"}, done, 1);
    chk({tag, ".busy_fin"}, busy, 0);
    chk({tag, ".pass"}, pass, ok);
    chk({tag, ".mismatch_count"}, mismatch_count, mc);
    chk({tag, ".first_err_idx"}, first_err_idx, fe);
    chk({tag, ".illegal"}, illegal_digit, ill);
    chk({tag, ".timeout"}, timeout, to);
`ifdef ONLINE_R4_VALUE_CHECK_EN
    chk({tag, ".value_match"}, value_match, vr == ve);
`endif
    tick;
    chk({tag, ".done_pulse"}, done, 0);
    chk({tag, ".pass_sticky"}, pass, ok);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".pass"}, pass, 0);
    chk({tag, ".mismatch_count"}, mismatch_count, 0);
    chk({tag, ".first_err_idx"}, first_err_idx, 7);
    chk({tag, ".illegal"}, illegal_digit, 0);
    chk({tag, ".timeout"}, timeout, 0);
  endtask

  initial begin
    #12;
    chk_reset_vals("reset");
    rst_n = 1'b1;
    tick;
    ev = '{1, -1, 0, -1, 2, 2, 1};
    gv = ev;
    run_check("exact", 0, 7, 1'b0, 1'b0);
    gv = '{1, -1, 0, 1, 2, 2, 1};
    run_check("single_err", 0, 7, 1'b0, 1'b0);
    gv = '{0, 3, 0, -1, 2, 2, 1};
    run_check("redundant", 0, 7, 1'b0, 1'b0);
    gv = '{1, -1, 0, -1, 2, -4, 1};
    run_check("illegal_gaps", 3, 7, 1'b0, 1'b0);
    gv = ev;
    run_check("timeout", 0, 2, 1'b0, 1'b0);
    run_check("start_with_valid", 0, 7, 1'b1, 1'b0);
    run_check("start_while_busy", 1, 7, 1'b0, 1'b1);
    gv = '{1, -4, 0, 2, 2, 2, 1};
    exp_z = pack_exp();
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dig_valid = 1'b1;
      dig_in = 3'(gv[i]);
      tick;
    end
    dig_valid = 1'b0;
    chk("pre_reset.illegal", illegal_digit, 1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("mid_reset");
    tick;
    rst_n = 1'b1;
    tick;
    gv = ev;
    run_check("after_reset", 0, 7, 1'b0, 1'b0);
    for (int k = 0; k < 24; k++) begin
      for (int i = 0; i < 7; i++) begin
        ev[i] = int'($urandom_range(0, 6)) - 3;
        gv[i] = ev[i];
        if ($urandom_range(0, 9) < 2) gv[i] = int'($urandom_range(0, 7)) - 4;
      end
      run_check($sformatf("rand%0d", k), int'($urandom_range(0, 2)), 7, 1'($urandom_range(0, 1)), 1'b0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
    $fatal(1, "watchdog");
  end
endmodule
